// File: rtl/riscv_isa_pkg.sv
// Shared RV32 ISA definitions: instruction type codes, opcodes and the
// encoded-entry payload used by the encoder, decoder and image builders.
package riscv_isa_pkg;

  localparam int unsigned INSTR_LEN = 32;
  localparam int unsigned ADDR_LEN  = 32;
  localparam int unsigned TYPE_LEN  = 3;

  localparam logic [TYPE_LEN-1:0] R_TYPE  = 3'd0;
  localparam logic [TYPE_LEN-1:0] I_TYPE  = 3'd1;
  localparam logic [TYPE_LEN-1:0] S_TYPE  = 3'd2;
  localparam logic [TYPE_LEN-1:0] SB_TYPE = 3'd3;
  localparam logic [TYPE_LEN-1:0] U_TYPE  = 3'd4;
  localparam logic [TYPE_LEN-1:0] UJ_TYPE = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef struct packed {
    logic [INSTR_LEN-1:0] instr;
    logic [ADDR_LEN-1:0]  addr;
    logic                 err;
  } enc_entry_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32 field packing with immediate range/alignment checking.
// Errored words are still packed from the truncated immediate bits.
module instr_pack
  import riscv_isa_pkg::*;
#(
  parameter int unsigned INSTRUCTION_LENGTH = 32,
  parameter int unsigned TYPE_WIDTH         = 3,
  parameter int unsigned REGISTER_WIDTH     = 5,
  parameter int unsigned IMMEDIATE_WIDTH    = 32
) (
  input  logic [TYPE_WIDTH-1:0]         type_i,
  input  logic [6:0]                    opcode_i,
  input  logic [2:0]                    funct3_i,
  input  logic [6:0]                    funct7_i,
  input  logic [REGISTER_WIDTH-1:0]     rd_i,
  input  logic [REGISTER_WIDTH-1:0]     rs1_i,
  input  logic [REGISTER_WIDTH-1:0]     rs2_i,
  input  logic [IMMEDIATE_WIDTH-1:0]    imm_i,
  output logic [INSTRUCTION_LENGTH-1:0] instr_c_o,
  output logic                          err_c_o
);

  localparam int unsigned IW = IMMEDIATE_WIDTH;

  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        sext12_ok;
  logic        sext13_ok;
  logic        sext21_ok;
  logic [31:0] word;
  logic        err;

  assign rd  = 5'(rd_i);
  assign rs1 = 5'(rs1_i);
  assign rs2 = 5'(rs2_i);

  // Immediate is a sign extension of its low N bits when all bits above N-1 agree.
  assign sext12_ok = (&imm_i[IW-1:11]) | (~|imm_i[IW-1:11]);
  assign sext13_ok = (&imm_i[IW-1:12]) | (~|imm_i[IW-1:12]);
  assign sext21_ok = (&imm_i[IW-1:20]) | (~|imm_i[IW-1:20]);

  always_comb begin
    word = '0;
    err  = 1'b0;
    case (type_i)
      TYPE_WIDTH'(R_TYPE): begin
        word = {funct7_i, rs2, rs1, funct3_i, rd, opcode_i};
      end
      TYPE_WIDTH'(I_TYPE): begin
        word = {imm_i[11:0], rs1, funct3_i, rd, opcode_i};
        err  = !sext12_ok;
      end
      TYPE_WIDTH'(S_TYPE): begin
        word = {imm_i[11:5], rs2, rs1, funct3_i, imm_i[4:0], opcode_i};
        err  = !sext12_ok;
      end
      TYPE_WIDTH'(SB_TYPE): begin
        word = {imm_i[12], imm_i[10:5], rs2, rs1, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
        err  = !sext13_ok || imm_i[0];
      end
      TYPE_WIDTH'(U_TYPE): begin
        word = {imm_i[31:12], rd, opcode_i};
        err  = |imm_i[11:0];
      end
      TYPE_WIDTH'(UJ_TYPE): begin
        word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd, opcode_i};
        err  = !sext21_ok || imm_i[0];
      end
      default: begin
        word = '0;
        err  = 1'b1;
      end
    endcase
  end

  assign instr_c_o = INSTRUCTION_LENGTH'(word);
  assign err_c_o   = err;

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32 instruction encoder: packs fields, tags each word with a
// running byte address and buffers results in a 2-entry head/tail FIFO.
module instr_encoder
  import riscv_isa_pkg::*;
#(
  parameter int unsigned INSTRUCTION_LENGTH = 32,
  parameter int unsigned TYPE_WIDTH         = 3,
  parameter int unsigned REGISTER_WIDTH     = 5,
  parameter int unsigned IMMEDIATE_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned ERR_CNT_WIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [TYPE_WIDTH-1:0]         in_type,
  input  logic [6:0]                    in_opcode,
  input  logic [2:0]                    in_funct3,
  input  logic [6:0]                    in_funct7,
  input  logic [REGISTER_WIDTH-1:0]     in_rd,
  input  logic [REGISTER_WIDTH-1:0]     in_rs1,
  input  logic [REGISTER_WIDTH-1:0]     in_rs2,
  input  logic [IMMEDIATE_WIDTH-1:0]    in_imm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INSTRUCTION_LENGTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic                          out_err,
  output logic [ERR_CNT_WIDTH-1:0]      err_count
);

  logic [INSTRUCTION_LENGTH-1:0] pack_instr;
  logic                          pack_err;

  instr_pack #(
    .INSTRUCTION_LENGTH(INSTRUCTION_LENGTH),
    .TYPE_WIDTH        (TYPE_WIDTH),
    .REGISTER_WIDTH    (REGISTER_WIDTH),
    .IMMEDIATE_WIDTH   (IMMEDIATE_WIDTH)
  ) u_pack (
    .type_i   (in_type),
    .opcode_i (in_opcode),
    .funct3_i (in_funct3),
    .funct7_i (in_funct7),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .imm_i    (in_imm),
    .instr_c_o(pack_instr),
    .err_c_o  (pack_err)
  );

  logic [1:0]                    count_q, count_d;
  logic [INSTRUCTION_LENGTH-1:0] head_instr_q, head_instr_d;
  logic [ADDR_WIDTH-1:0]         head_addr_q, head_addr_d;
  logic                          head_err_q, head_err_d;
  logic [INSTRUCTION_LENGTH-1:0] tail_instr_q, tail_instr_d;
  logic [ADDR_WIDTH-1:0]         tail_addr_q, tail_addr_d;
  logic                          tail_err_q, tail_err_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [ERR_CNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;
  logic                          push;
  logic                          pop;

  assign in_ready  = (count_q != 2'd2) && !flush;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head always holds the oldest word so the outputs come straight from flops.
  always_comb begin
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_addr_d  = head_addr_q;
    head_err_d   = head_err_q;
    tail_instr_d = tail_instr_q;
    tail_addr_d  = tail_addr_q;
    tail_err_d   = tail_err_q;
    addr_d       = addr_q;
    err_cnt_d    = err_cnt_q;
    if (flush) begin
      count_d = 2'd0;
      addr_d  = BASE_ADDR;
    end else begin
      if (push) begin
        addr_d = addr_q + ADDR_WIDTH'(4);
        if (pack_err && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
      end
      case (count_q)
        2'd0: begin
          if (push) begin
            head_instr_d = pack_instr;
            head_addr_d  = addr_q;
            head_err_d   = pack_err;
            count_d      = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_instr_d = pack_instr;
            head_addr_d  = addr_q;
            head_err_d   = pack_err;
          end else if (push) begin
            tail_instr_d = pack_instr;
            tail_addr_d  = addr_q;
            tail_err_d   = pack_err;
            count_d      = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_instr_d = tail_instr_q;
            head_addr_d  = tail_addr_q;
            head_err_d   = tail_err_q;
            count_d      = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= 2'd0;
      head_instr_q <= '0;
      head_addr_q  <= '0;
      head_err_q   <= 1'b0;
      tail_instr_q <= '0;
      tail_addr_q  <= '0;
      tail_err_q   <= 1'b0;
      addr_q       <= BASE_ADDR;
      err_cnt_q    <= '0;
    end else begin
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_addr_q  <= head_addr_d;
      head_err_q   <= head_err_d;
      tail_instr_q <= tail_instr_d;
      tail_addr_q  <= tail_addr_d;
      tail_err_q   <= tail_err_d;
      addr_q       <= addr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_instr = head_instr_q;
  assign out_addr  = head_addr_q;
  assign out_err   = head_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed test-plan words, backpressure,
// flush, mid-stream reset and randomized traffic against a behavioural model.
module tb_instr_encoder;
  import riscv_isa_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_type  (in_type),
    .in_opcode(in_opcode),
    .in_funct3(in_funct3),
    .in_funct7(in_funct7),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_imm   (in_imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_addr (out_addr),
    .out_err  (out_err),
    .err_count(err_count)
  );

  enc_entry_t  exp_q[$];
  logic [31:0] exp_addr;
  int          exp_errcnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: field placement by shift/mask, error by signed range.
  task automatic ref_encode(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm,
                            output logic [31:0] w, output logic e);
    int s;
    logic [31:0] base;
    s    = $signed(imm);
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    e    = 1'b0;
    case (t)
      3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
      3'd1: begin
        w = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7);
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
            | base | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
        e = (s < -4096) || (s > 4095) || (imm % 2 != 0);
      end
      3'd4: begin
        w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
        e = (imm % 4096) != 0;
      end
      3'd5: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
            | (32'(rd) << 7) | 32'(op);
        e = (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
      end
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
  endtask

  // Holds a word on the input until accepted; expectation is queued at acceptance.
  task automatic drive(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [31:0] e_instr, input logic e_err, output int waits);
    enc_entry_t ent;
    bit done;
    done = 1'b0;
    waits = 0;
    in_type = t; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      waits++;
      if (in_ready) begin
        ent.instr = e_instr;
        ent.addr  = exp_addr;
        ent.err   = e_err;
        exp_q.push_back(ent);
        exp_addr = exp_addr + 32'd4;
        if (e_err && exp_errcnt < 255) exp_errcnt++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed low for 200 cycles at %0t", $time);
    end
  endtask

  task automatic send_rand(output int waits);
    logic [2:0]  t;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, w;
    logic        e;
    t = 3'($urandom_range(0, 7));
    op = 7'($urandom); f7 = 7'($urandom); f3 = 3'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case ($urandom_range(0, 4))
      0: imm = $urandom;
      1: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      2: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      3: imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
      default: imm = $urandom & 32'hFFFFF000;
    endcase
    ref_encode(t, op, f3, f7, rd, rs1, rs2, imm, w, e);
    drive(t, op, f3, f7, rd, rs1, rs2, imm, w, e, waits);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && (exp_q.size() != 0 || out_valid); i++) @(posedge clk);
    #1;
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Monitor: the head is checked once, in the cycle it is popped.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: instr 0x%08h addr 0x%08h with empty scoreboard", out_instr, out_addr);
      end else begin
        enc_entry_t e;
        e = exp_q.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_addr", out_addr, e.addr);
        chk("out_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  int  w;
  bit  rand_done;

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_type = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_addr = 32'd0; exp_errcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed words with hand-computed encodings.
    out_ready = 1'b1;
    drive(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, w);
    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, w);
    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h80000093, 1'b1, w);
    @(negedge clk);
    chk("err_count_after_addi", 32'(err_count), 32'd1);
    @(posedge clk);
    #1;
    drive(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, w);
    drive(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h00000003, 32'h00000163, 1'b1, w);
    drive(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0, w);
    drive(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 32'h123452B7, 1'b1, w);
    drive(3'd6, 7'h33, 3'd1, 7'h7F, 5'd9, 5'd9, 5'd9, 32'd0, 32'h00000000, 1'b1, w);
    wait_drain();
    chk("err_count_directed", 32'(err_count), 32'(exp_errcnt));

    // Mid-stream reset with the FIFO full.
    out_ready = 1'b0;
    drive(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0, w);
    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 32'h80000093, 1'b1, w);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    exp_q.delete();
    exp_addr = 32'd0;
    exp_errcnt = 0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Backpressure: two words fill the FIFO, the third stalls until drain.
    drive(3'd0, 7'h33, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0, 32'h00628233, 1'b0, w);
    drive(3'd1, 7'h13, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd5, 32'h00500393, 1'b0, w);
    fork
      begin
        drive(3'd4, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hABCDE000, 32'hABCDE0B7, 1'b0, w);
        chk("bp_third_stalled", 32'(w > 1), 32'd1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Back-to-back stream with out_ready high: count stays at 1, no stalls.
    for (int i = 0; i < 16; i++) begin
      send_rand(w);
      if (i > 0) chk("stream_no_stall", 32'(w), 32'd1);
    end
    wait_drain();

    // Flush with the FIFO full: contents dropped, address restarts.
    out_ready = 1'b0;
    send_rand(w);
    send_rand(w);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_err_count", 32'(err_count), 32'(exp_errcnt));
    exp_q.delete();
    exp_addr = 32'd0;
    out_ready = 1'b1;
    drive(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd8, 32'hFFFFFFF8, 32'hFE812C23, 1'b0, w);
    wait_drain();

    // Randomized traffic with random consumer backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) send_rand(w);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    chk("err_count_random", 32'(err_count), 32'(exp_errcnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RISC-V RV32 instruction encoder. It is the inverse of the field-extraction decoder: it takes an instruction type, opcode/funct fields, register numbers and a 32-bit immediate, and packs them into a 32-bit instruction word.
- Range and alignment of the immediate are checked.
- Each word is tagged with a running byte address.
- Results are buffered in a 2-entry output FIFO with valid/ready handshakes on both sides.
- Used by the self-test program generator and by the bench to build instruction-memory images.

Parameters:
INSTRUCTION_LENGTH, 32, encoded word width
TYPE_WIDTH, 3, instruction type code width
REGISTER_WIDTH, 5, register number width
IMMEDIATE_WIDTH, 32, immediate input width
ADDR_WIDTH, 32, address counter width
BASE_ADDR, 0, address of first emitted word after reset/flush
ERR_CNT_WIDTH, 8, saturating error counter width

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO and address counter
in_valid  input  1  input fields valid
in_ready  output  1  encoder can accept
in_type  input  TYPE_WIDTH  R/I/S/SB/U/UJ code
in_opcode  input  7  opcode [6:0]
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (R type only)
in_rd  input  REGISTER_WIDTH  destination register number
in_rs1  input  REGISTER_WIDTH  source 1 register number
in_rs2  input  REGISTER_WIDTH  source 2 register number
in_imm  input  IMMEDIATE_WIDTH  immediate, sign-extended byte value
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_instr  output  INSTRUCTION_LENGTH  encoded word
out_addr  output  ADDR_WIDTH  byte address of word
out_err  output  1  immediate/type error for this word
err_count  output  ERR_CNT_WIDTH  saturating count of accepted words with error

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO empty; out_valid=0.
  - out_instr, out_addr and out_err read 0.
  - Address counter = BASE_ADDR; err_count = 0.
  - Any in-flight words are discarded.
- Accepting a word:
  - A word is accepted on a rising edge with in_valid && in_ready.
  - in_ready = (count < 2) && !flush. It is registered-count based and has no combinational dependency on out_ready.
- Popping a word: the head is popped on a rising edge with out_valid && out_ready.
- Latency:
  - A word accepted into an empty FIFO appears on out_* in the next cycle.
  - Order is strictly FIFO.
- Simultaneous push and pop:
  - At count 1, count stays 1 and the new word becomes head.
  - At count 2, no push is possible.
- Address counter:
  - The word gets the current counter value.
  - The counter increments by 4 per accepted word and wraps modulo 2^ADDR_WIDTH.
  - Errored words still consume an address.
- flush:
  - Empties the FIFO and reloads BASE_ADDR next edge; err_count is unchanged.
  - flush has priority over push and pop in the same cycle.
- Encoding, with opcode always at [6:0]:
  - R: funct7[31:25] rs2[24:20] rs1[19:15] funct3[14:12] rd[11:7].
  - I: imm[11:0]→[31:20], rs1, funct3, rd.
  - S: imm[11:5]→[31:25], rs2, rs1, funct3, imm[4:0]→[11:7].
  - SB: imm[12]→[31], imm[10:5]→[30:25], rs2, rs1, funct3, imm[4:1]→[11:8], imm[11]→[7].
  - U: imm[31:12]→[31:12], rd.
  - UJ: imm[20]→[31], imm[10:1]→[30:21], imm[11]→[20], imm[19:12]→[19:12], rd.
- Error (out_err=1) when any of the following holds. The word is still encoded from truncated bits.
  - I/S: imm is not the sign-extension of imm[11:0].
  - SB: imm is not the sign-extension of imm[12:0], or imm[0]=1.
  - UJ: imm is not the sign-extension of imm[20:0], or imm[0]=1.
  - U: imm[11:0] != 0.
  - Type code 6 or 7: word = 0, out_err=1.
- err_count increments on each accepted errored word and saturates at all-ones.

Decomposition:
- Shared package riscv_isa_pkg holds:
  - Type codes R_TYPE=0, I_TYPE=1, S_TYPE=2, SB_TYPE=3, U_TYPE=4, UJ_TYPE=5.
  - Opcode constants.
  - Encoded-entry struct {instr, addr, err}.
  - The decoder reuses the same type codes.
- Sub-module instr_pack: purely combinational field packing plus error check.
- The top holds the 2-entry FIFO, handshakes, address counter and err_count.

Test Plan:
- R add x3,x1,x2 (opcode 0x33, f3 0, f7 0) after reset → next cycle out_instr=0x002081B3, out_addr=0, out_err=0.
- I addi x1,x0,imm=0xFFFFFFFF (opcode 0x13) → 0xFFF00093, err 0. Same with imm=0x800 → err 1, err_count 1.
- SB beq x0,x0,imm=-4 (opcode 0x63) → 0xFE000EE3, err 0. Same with imm=3 → err 1.
- U lui x5,imm=0x12345000 (opcode 0x37) → 0x123452B7, err 0. imm=0x12345001 → err 1.
- Backpressure: out_ready=0, push 3 words.
  - Expect in_ready low after 2 accepts.
  - Release out_ready: words drain in order with addr 0 and 4, then the third is accepted with addr 8.
  - At count 1 with push and pop together, count stays 1.
- With FIFO full:
  - Assert flush: FIFO empties, next word has addr BASE_ADDR.
  - Pulse reset_n low mid-stream: out_valid drops immediately, err_count=0.
